// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong game-flow logic: FSM state encoding,
// score width, player ids and BCD-pair to binary conversion.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SERVE,
        PLAY,
        SCORE,
        WAIT,
        CHECK,
        OVER
    } state_e;

    localparam int SCORE_W = 7;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

    // 10*tens + units, built from shifts so no multiplier is inferred.
    function automatic logic [SCORE_W-1:0] bcd2_to_bin(input logic [3:0] tens,
                                                       input logic [3:0] units);
        logic [SCORE_W-1:0] t;
        logic [SCORE_W-1:0] u;
        t = SCORE_W'(tens);
        u = SCORE_W'(units);
        return (t << 3) + (t << 1) + u;
    endfunction

endpackage

// File: rtl/pong_score_ctrl_serve_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
// Used for serve delays and intended for reuse on paddle-reset delays.
module serve_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/pong_score_ctrl.sv
// Game-flow controller for the two-player pong score counter.
// Optional build macro WIN_BY_TWO_EN: a win additionally needs a 2-point lead.
module pong_score_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_TICKS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       point_A,
    input  logic       point_B,
    input  logic [3:0] dig0_A,
    input  logic [3:0] dig1_A,
    input  logic [3:0] dig0_B,
    input  logic [3:0] dig1_B,
    output logic       d_inc_A,
    output logic       d_inc_B,
    output logic       d_clr,
    output logic       ball_hold,
    output logic       game_over,
    output logic       winner
);

    import pong_pkg::*;

    localparam int                 TIMER_W    = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_TARGET = SCORE_W'(WIN_SCORE);

    state_e state_q, state_d;
    logic   d_inc_a_q, d_inc_a_d;
    logic   d_inc_b_q, d_inc_b_d;
    logic   d_clr_q, d_clr_d;
    logic   ball_hold_q, ball_hold_d;
    logic   game_over_q, game_over_d;
    logic   winner_q, winner_d;

    logic               timer_load;
    logic               timer_en;
    logic               timer_done;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               win;
    logic               win_player;

    serve_timer #(
        .WIDTH(TIMER_W)
    ) u_serve_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .en      (timer_en),
        .load_val(SERVE_LOAD),
        .done    (timer_done)
    );

    // Digits are only consumed in CHECK, one cycle after the counter updated.
    assign score_a = bcd2_to_bin(dig1_A, dig0_A);
    assign score_b = bcd2_to_bin(dig1_B, dig0_B);

`ifdef WIN_BY_TWO_EN
    localparam logic [SCORE_W-1:0] LEAD_MIN  = SCORE_W'(2);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(99);

    logic               a_ahead;
    logic [SCORE_W-1:0] top_score;
    logic [SCORE_W-1:0] lead;

    // A leader sitting at 99 always wins so the counter never wraps.
    always_comb begin
        a_ahead    = (score_a > score_b);
        top_score  = a_ahead ? score_a : score_b;
        lead       = a_ahead ? (score_a - score_b) : (score_b - score_a);
        win        = ((top_score >= WIN_TARGET) && (lead >= LEAD_MIN)) ||
                     ((top_score == SCORE_MAX) && (lead != '0));
        win_player = a_ahead ? PLAYER_A : PLAYER_B;
    end
`else
    always_comb begin
        win        = (score_a >= WIN_TARGET) || (score_b >= WIN_TARGET);
        win_player = (score_a >= WIN_TARGET) ? PLAYER_A : PLAYER_B;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = SERVE;
            SERVE:   if (timer_done) state_d = PLAY;
            PLAY:    if (point_A || point_B) state_d = SCORE;
            SCORE:   state_d = WAIT;
            WAIT:    state_d = CHECK;
            CHECK:   state_d = win ? OVER : SERVE;
            OVER:    if (start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    // Timer loads on every entry to SERVE, from CLEAR or from a non-winning CHECK.
    assign timer_load = (state_d == SERVE) && (state_q != SERVE);
    assign timer_en   = (state_q == SERVE);

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        d_clr_d     = (state_d == CLEAR);
        d_inc_a_d   = (state_q == PLAY) && point_A;
        d_inc_b_d   = (state_q == PLAY) && !point_A && point_B;
        ball_hold_d = (state_d != PLAY);
        game_over_d = (state_d == OVER);
        winner_d    = winner_q;
        if ((state_q == CHECK) && win) begin
            winner_d = win_player;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            d_inc_a_q   <= 1'b0;
            d_inc_b_q   <= 1'b0;
            d_clr_q     <= 1'b0;
            ball_hold_q <= 1'b1;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_inc_a_q   <= d_inc_a_d;
            d_inc_b_q   <= d_inc_b_d;
            d_clr_q     <= d_clr_d;
            ball_hold_q <= ball_hold_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign d_inc_A   = d_inc_a_q;
    assign d_inc_B   = d_inc_b_q;
    assign d_clr     = d_clr_q;
    assign ball_hold = ball_hold_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Randomised scoreboard bench for pong_score_ctrl (WIN_SCORE = 3, SERVE_TICKS = 4)
// with a behavioural BCD score counter closing the loop.
module tb_pong_score_ctrl;

    localparam int WIN = 3;
    localparam int ST  = 4;
    localparam int N_CYCLES = 4000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic point_A = 1'b0;
    logic point_B = 1'b0;
    logic [3:0] dig0_A, dig1_A, dig0_B, dig1_B;
    logic d_inc_A, d_inc_B, d_clr, ball_hold, game_over, winner;

    always #5 clk = ~clk;

    pong_score_ctrl #(
        .WIN_SCORE  (WIN),
        .SERVE_TICKS(ST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .point_A  (point_A),
        .point_B  (point_B),
        .dig0_A   (dig0_A),
        .dig1_A   (dig1_A),
        .dig0_B   (dig0_B),
        .dig1_B   (dig1_B),
        .d_inc_A  (d_inc_A),
        .d_inc_B  (d_inc_B),
        .d_clr    (d_clr),
        .ball_hold(ball_hold),
        .game_over(game_over),
        .winner   (winner)
    );

    // Environment: the BCD score counter the controller drives.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    logic [7:0] cnt_a, cnt_b;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a <= 8'h00;
            cnt_b <= 8'h00;
        end else if (d_clr) begin
            cnt_a <= 8'h00;
            cnt_b <= 8'h00;
        end else if (d_inc_A) begin
            cnt_a <= bcd_inc(cnt_a);
        end else if (d_inc_B) begin
            cnt_b <= bcd_inc(cnt_b);
        end
    end
    assign dig1_A = cnt_a[7:4];
    assign dig0_A = cnt_a[3:0];
    assign dig1_B = cnt_b[7:4];
    assign dig0_B = cnt_b[3:0];

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    typedef enum {EV_CLR, EV_INC_A, EV_INC_B, EV_PLAY, EV_OVER} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       at;
        logic     who;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model: game phase with the cycle at which it changes.
    typedef enum {M_IDLE, M_TO_PLAY, M_PLAY, M_TO_OVER, M_OVER} mode_e;
    mode_e m_mode = M_IDLE;
    int    m_at = 0;
    int    sa = 0;
    int    sb = 0;

    function automatic bit game_won(input int a, input int b, output logic who);
        int mx;
        int lead;
        mx   = (a > b) ? a : b;
        lead = (a > b) ? a - b : b - a;
        who  = (b > a) ? 1'b1 : 1'b0;
`ifdef WIN_BY_TWO_EN
        return ((mx >= WIN) && (lead >= 2)) || ((mx >= 99) && (lead >= 1));
`else
        if (a >= WIN) begin
            who = 1'b0;
            return 1'b1;
        end
        if (b >= WIN) begin
            who = 1'b1;
            return 1'b1;
        end
        return 1'b0;
`endif
    endfunction

    task automatic expect_ev(input ev_kind_e k, input int at, input logic who);
        ev_t e;
        e.kind = k;
        e.at   = at;
        e.who  = who;
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle();
        bit   do_start, pa, pb, won;
        logic who;
        start   = 1'b0;
        point_A = 1'b0;
        point_B = 1'b0;
        if (m_mode == M_TO_PLAY && cyc >= m_at) m_mode = M_PLAY;
        if (m_mode == M_TO_OVER && cyc >= m_at) m_mode = M_OVER;
        if (reset) begin
            reset = 1'b0;
        end else if (cyc > 10 && $urandom_range(0, 149) == 0) begin
            reset = 1'b1;
            exp_q.delete();
            m_mode = M_IDLE;
            $display("[TB] cyc %0d reset asserted", cyc);
            return;
        end
        do_start = (m_mode == M_IDLE || m_mode == M_OVER) ? ($urandom_range(0, 5) == 0)
                                                          : ($urandom_range(0, 15) == 0);
        pa = ($urandom_range(0, 2) == 0);
        pb = ($urandom_range(0, 2) == 0);
        start   = do_start;
        point_A = pa;
        point_B = pb;
        if (do_start && (m_mode == M_IDLE || m_mode == M_OVER)) begin
            sa = 0;
            sb = 0;
            expect_ev(EV_CLR, cyc + 1, 1'b0);
            expect_ev(EV_PLAY, cyc + 2 + ST, 1'b0);
            m_mode = M_TO_PLAY;
            m_at   = cyc + 2 + ST;
            $display("[TB] cyc %0d start accepted", cyc);
        end else if ((pa || pb) && m_mode == M_PLAY) begin
            if (pa) begin
                sa++;
                expect_ev(EV_INC_A, cyc + 1, 1'b0);
            end else begin
                sb++;
                expect_ev(EV_INC_B, cyc + 1, 1'b0);
            end
            won = game_won(sa, sb, who);
            if (won) begin
                expect_ev(EV_OVER, cyc + 4, who);
                m_mode = M_TO_OVER;
                m_at   = cyc + 4;
            end else begin
                expect_ev(EV_PLAY, cyc + 4 + ST, 1'b0);
                m_mode = M_TO_PLAY;
                m_at   = cyc + 4 + ST;
            end
            $display("[TB] cyc %0d point a=%0b b=%0b score %0d-%0d won=%0b", cyc, pa, pb, sa, sb, won);
        end
    endtask

    task automatic match_ev(input ev_kind_e k, input logic who);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: cyc %0d got %s, expected nothing", cyc, k.name());
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.at != cyc || (k == EV_OVER && e.who !== who)) begin
            n_fail++;
            $display("FAIL event: got %s at cyc %0d winner %0b, expected %s at cyc %0d winner %0b",
                     k.name(), cyc, who, e.kind.name(), e.at, e.who);
        end else begin
            $display("[TB] cyc %0d event %s ok", cyc, k.name());
        end
    endtask

    logic prev_hold = 1'b1;
    logic prev_over = 1'b0;

    // Monitor: samples on the falling edge, turns output edges into events.
    always @(negedge clk) begin
        if (reset) begin
            n_tests++;
            if ({d_clr, d_inc_A, d_inc_B, ball_hold, game_over, winner} !== 6'b000100) begin
                n_fail++;
                $display("FAIL reset_state: cyc %0d got clr/incA/incB/hold/over/win=%b, expected 000100",
                         cyc, {d_clr, d_inc_A, d_inc_B, ball_hold, game_over, winner});
            end
        end else begin
            n_tests++;
            if (int'(d_clr) + int'(d_inc_A) + int'(d_inc_B) > 1) begin
                n_fail++;
                $display("FAIL strobe_exclusive: cyc %0d got clr=%b incA=%b incB=%b, expected at most one",
                         cyc, d_clr, d_inc_A, d_inc_B);
            end
            if (d_clr) match_ev(EV_CLR, 1'b0);
            if (d_inc_A) match_ev(EV_INC_A, 1'b0);
            if (d_inc_B) match_ev(EV_INC_B, 1'b0);
            if ((d_inc_A || d_inc_B) && !ball_hold) begin
                n_tests++;
                n_fail++;
                $display("FAIL hold_on_score: cyc %0d got ball_hold=0, expected 1", cyc);
            end
            if (prev_hold && !ball_hold) match_ev(EV_PLAY, 1'b0);
            if (!prev_over && game_over) match_ev(EV_OVER, winner);
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_event: got nothing, expected %s at cyc %0d",
                         exp_q[0].kind.name(), exp_q[0].at);
                void'(exp_q.pop_front());
            end
        end
        prev_hold = ball_hold;
        prev_over = game_over;
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < N_CYCLES; i++) begin
            @(posedge clk);
            #2;
            drive_cycle();
        end
        @(posedge clk);
        #2;
        reset   = 1'b0;
        start   = 1'b0;
        point_A = 1'b0;
        point_B = 1'b0;
        repeat (ST + 12) @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d events still pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
